// File: rtl/reg_write_tracker_pkg.sv
// Shared definitions for the register-write tracker: opcode/func constants,
// forwarding-select encoding, the in-flight destination tag type, and the
// R-type "does this func write rd" helper.
package reg_write_tracker_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type func codes
  localparam logic [5:0] F_SLL     = 6'd0;
  localparam logic [5:0] F_SRL     = 6'd2;
  localparam logic [5:0] F_SRA     = 6'd3;
  localparam logic [5:0] F_SRLV    = 6'd6;
  localparam logic [5:0] F_JR      = 6'd8;
  localparam logic [5:0] F_SYSCALL = 6'd12;
  localparam logic [5:0] F_ADD     = 6'd32;
  localparam logic [5:0] F_ADDU    = 6'd33;
  localparam logic [5:0] F_SUB     = 6'd34;
  localparam logic [5:0] F_AND     = 6'd36;
  localparam logic [5:0] F_OR      = 6'd37;
  localparam logic [5:0] F_XOR     = 6'd38;
  localparam logic [5:0] F_NOR     = 6'd39;
  localparam logic [5:0] F_SLT     = 6'd42;
  localparam logic [5:0] F_SLTU    = 6'd43;

  // Operand source select for the ID/EX latch
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Destination tag carried alongside an in-flight instruction
  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       ld;
  } tag_t;

  localparam tag_t TagBubble = '{vld: 1'b0, dst: 5'd0, ld: 1'b0};

  function automatic logic rtype_writes(input logic [5:0] func);
    logic w;
    case (func)
      F_SLL, F_SRL, F_SRA, F_SRLV,
      F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: w = 1'b1;
      F_JR, F_SYSCALL:                                               w = 1'b0;
      default:                                                       w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/reg_write_tracker_usage.sv
// Write-usage decoder: from opcode/func/rt/rd decides whether the ID
// instruction writes the register file, which register, and whether it is
// a load. A destination of $0 is reported as "no write".
// Ports:
//   op_i, func_i  opcode and R-type func field
//   rt_i, rd_i    candidate destination fields
//   wen_o         instruction writes a non-zero register
//   dst_o         destination register (0 when wen_o=0)
//   is_load_o     instruction is a load word
module reg_write_tracker_usage
  import reg_write_tracker_pkg::*;
#(
  parameter logic [4:0] RaReg = 5'd31
) (
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output logic       wen_o,
  output logic [4:0] dst_o,
  output logic       is_load_o
);

  logic       wen_raw;
  logic [4:0] dst_raw;

  always_comb begin
    wen_raw = 1'b0;
    dst_raw = 5'd0;
    case (op_i)
      OP_RTYPE: begin
        if (rtype_writes(func_i)) begin
          wen_raw = 1'b1;
          dst_raw = rd_i;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
        wen_raw = 1'b1;
        dst_raw = rt_i;
      end
      OP_JAL: begin
        wen_raw = 1'b1;
        dst_raw = RaReg;
      end
      OP_SW:   wen_raw = 1'b0;
      default: wen_raw = 1'b0;
    endcase
  end

  // $0 is hard-wired, so a write to it is never tracked
  assign wen_o     = wen_raw & (dst_raw != 5'd0);
  assign dst_o     = wen_o ? dst_raw : 5'd0;
  assign is_load_o = (op_i == OP_LW);

endmodule

// File: rtl/reg_write_tracker.sv
// Register-write tracker: decodes the ID instruction's destination, keeps
// destination tags for the instructions in EX/MEM/WB, and compares the ID
// source registers against them to produce the load-use stall, the operand
// forwarding selects and a saturating stall-cycle counter.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_valid             ID holds a real instruction
//   id_op/func/rs/rt/rd  ID instruction fields
//   r1_used, r2_used     ID instruction reads rs / rt
//   flush                kill the instruction entering EX
//   stall                load-use hazard (hold PC and IF/ID)
//   fwd_a, fwd_b         rs/rt source select: 0 RF, 1 EX, 2 MEM, 3 WB
//   id_wen, id_wdst      decoded write enable / destination of ID instr
//   stall_cnt            saturating count of stall cycles
module reg_write_tracker
  import reg_write_tracker_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned RA_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_func,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             r1_used,
  input  logic             r2_used,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_wen,
  output logic [4:0]       id_wdst,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [4:0] RaReg = 5'(RA_REG);

  logic id_is_load;

  reg_write_tracker_usage #(
    .RaReg (RaReg)
  ) u_usage (
    .op_i      (id_op),
    .func_i    (id_func),
    .rt_i      (id_rt),
    .rd_i      (id_rd),
    .wen_o     (id_wen),
    .dst_o     (id_wdst),
    .is_load_o (id_is_load)
  );

  tag_t ex_q, mem_q, wb_q;
  tag_t ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic src_match(input logic used, input logic [4:0] src, input tag_t tag);
    return used && (src != 5'd0) && tag.vld && (tag.dst == src);
  endfunction

  // Nearest producer wins: EX is younger than MEM, MEM than WB
  function automatic logic [1:0] pick_fwd(input logic m_ex, input logic m_mem, input logic m_wb);
    logic [1:0] sel;
    if (m_ex)       sel = FWD_EX;
    else if (m_mem) sel = FWD_MEM;
    else if (m_wb)  sel = FWD_WB;
    else            sel = FWD_RF;
    return sel;
  endfunction

  logic ma_ex, ma_mem, ma_wb;
  logic mb_ex, mb_mem, mb_wb;

  always_comb begin
    ma_ex  = src_match(r1_used, id_rs, ex_q);
    ma_mem = src_match(r1_used, id_rs, mem_q);
    ma_wb  = src_match(r1_used, id_rs, wb_q);
    mb_ex  = src_match(r2_used, id_rt, ex_q);
    mb_mem = src_match(r2_used, id_rt, mem_q);
    mb_wb  = src_match(r2_used, id_rt, wb_q);
  end

  // A load in EX has no data until MEM; flush outranks the stall since the
  // ID instruction is being discarded anyway.
  assign stall = id_valid & (ma_ex | mb_ex) & ex_q.ld & ~flush;

  // While stalled the ID/EX latch takes a bubble, so selects are don't-care
  // and held at RF; next cycle the load is in MEM and selects 2.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!stall) begin
      fwd_a = pick_fwd(ma_ex, ma_mem, ma_wb);
      fwd_b = pick_fwd(mb_ex, mb_mem, mb_wb);
    end
  end

  always_comb begin
    ex_d = TagBubble;
    if (id_valid && id_wen && !stall && !flush) begin
      ex_d = '{vld: 1'b1, dst: id_wdst, ld: id_is_load};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= TagBubble;
      mem_q <= TagBubble;
      wb_q  <= TagBubble;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_tracker.sv
module tb_reg_write_tracker;

  localparam int CntW  = 4;
  localparam int CntMx = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [5:0]      id_op, id_func;
  logic [4:0]      id_rs, id_rt, id_rd;
  logic            r1_used, r2_used, flush;
  logic            stall;
  logic [1:0]      fwd_a, fwd_b;
  logic            id_wen;
  logic [4:0]      id_wdst;
  logic [CntW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: what issued into EX on each of the last three cycles
  bit m_v[1:3];
  int m_dst[1:3];
  bit m_ld[1:3];
  int m_cnt;
  bit e_stall, e_wen, e_ld;
  int e_fa, e_fb, e_wdst;

  reg_write_tracker #(
    .CNT_W  (CntW),
    .RA_REG (31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_op     (id_op),
    .id_func   (id_func),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .r1_used   (r1_used),
    .r2_used   (r2_used),
    .flush     (flush),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .id_wen    (id_wen),
    .id_wdst   (id_wdst),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int nearest(bit used, int s);
    if (!used || s == 0) return 0;
    for (int age = 1; age <= 3; age++) if (m_v[age] && m_dst[age] == s) return age;
    return 0;
  endfunction

  task automatic model_eval();
    int d, op, fn, na, nb;
    op = int'(id_op);
    fn = int'(id_func);
    if (op == 0 && (fn inside {0, 2, 3, 6, 32, 33, 34, 36, 37, 38, 39, 42, 43})) d = int'(id_rd);
    else if (op inside {8, 9, 10, 12, 13, 35}) d = int'(id_rt);
    else if (op == 3) d = 31;
    else d = 0;
    e_wen  = (d != 0);
    e_wdst = d;
    e_ld   = (op == 35);
    na = nearest(r1_used, int'(id_rs));
    nb = nearest(r2_used, int'(id_rt));
    e_stall = id_valid && !flush && (na == 1 || nb == 1) && m_ld[1];
    e_fa = e_stall ? 0 : na;
    e_fb = e_stall ? 0 : nb;
  endtask

  task automatic drive(bit v, int op, int fn, int rs, int rt, int rd, bit u1, bit u2, bit fl);
    id_valid = v; id_op = 6'(op); id_func = 6'(fn);
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    r1_used = u1; r2_used = u2; flush = fl;
    #2;
    model_eval();
  endtask

  task automatic d_add(int rd, int rs, int rt); drive(1, 0, 32, rs, rt, rd, 1, 1, 0); endtask
  task automatic d_lw(int rt, int rs);          drive(1, 35, 0, rs, rt, 0, 1, 0, 0); endtask
  task automatic d_bub();                       drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask

  task automatic tick();
    if (rst) begin
      for (int a = 1; a <= 3; a++) begin m_v[a] = 0; m_dst[a] = 0; m_ld[a] = 0; end
      m_cnt = 0;
    end else begin
      for (int a = 3; a >= 2; a--) begin
        m_v[a] = m_v[a-1]; m_dst[a] = m_dst[a-1]; m_ld[a] = m_ld[a-1];
      end
      m_v[1]   = id_valid && e_wen && !e_stall && !flush;
      m_dst[1] = m_v[1] ? e_wdst : 0;
      m_ld[1]  = m_v[1] && e_ld;
      if (e_stall && m_cnt < CntMx) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin d_bub(); tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_add(3, 1, 2);
    tick(); tick();
    d_add(3, 1, 2);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    checks++; if (id_wen !== 1'b1 || id_wdst !== 5'd3) begin
      errors++; $display("FAIL reset_decode got %b/%0d want 1/3", id_wen, id_wdst); end
    rst = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_ex_forward();
    d_add(3, 1, 2);
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL exfwd_first got %0d/%0d want 0/0", fwd_a, fwd_b); end
    tick();
    d_add(4, 3, 3);
    checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1 || stall !== 1'b0) begin
      errors++; $display("FAIL exfwd got a=%0d b=%0d st=%b want 1/1/0", fwd_a, fwd_b, stall); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    int c0;
    c0 = int'(stall_cnt);
    d_lw(5, 1); tick();
    d_add(6, 5, 0);
    checks++; if (stall !== 1'b1 || fwd_a !== 2'd0) begin
      errors++; $display("FAIL lduse_stall got st=%b a=%0d want 1/0", stall, fwd_a); end
    tick();
    d_add(6, 5, 0);
    checks++; if (int'(stall_cnt) !== c0 + 1) begin
      errors++; $display("FAIL lduse_cnt got %0d want %0d", stall_cnt, c0 + 1); end
    checks++; if (stall !== 1'b0 || fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL lduse_after got st=%b a=%0d b=%0d want 0/2/0", stall, fwd_a, fwd_b); end
    tick();
    drain();
  endtask

  task automatic test_store();
    d_lw(5, 1); tick();
    drive(1, 43, 0, 2, 5, 0, 1, 1, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sw_stall got %b want 1", stall); end
    tick();
    drive(1, 43, 0, 2, 5, 0, 1, 1, 0);
    checks++; if (stall !== 1'b0 || fwd_b !== 2'd2 || id_wen !== 1'b0) begin
      errors++; $display("FAIL sw_after got st=%b b=%0d wen=%b want 0/2/0", stall, fwd_b, id_wen); end
    tick();
    drain();
    d_lw(5, 1); tick();
    drive(1, 43, 0, 2, 7, 0, 1, 1, 0);
    checks++; if (stall !== 1'b0 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL sw_unrel got st=%b a=%0d b=%0d want 0/0/0", stall, fwd_a, fwd_b); end
    tick();
    drain();
  endtask

  task automatic test_zero_and_jal();
    drive(1, 8, 0, 1, 0, 0, 1, 0, 0);
    checks++; if (id_wen !== 1'b0 || id_wdst !== 5'd0) begin
      errors++; $display("FAIL addi0_decode got %b/%0d want 0/0", id_wen, id_wdst); end
    tick();
    d_add(2, 0, 0);
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL zero_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    tick();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (id_wen !== 1'b1 || id_wdst !== 5'd31) begin
      errors++; $display("FAIL jal_decode got %b/%0d want 1/31", id_wen, id_wdst); end
    tick();
    drive(1, 0, 8, 31, 0, 0, 1, 0, 0);
    checks++; if (fwd_a !== 2'd1 || id_wen !== 1'b0) begin
      errors++; $display("FAIL jr_fwd got a=%0d wen=%b want 1/0", fwd_a, id_wen); end
    tick();
    drain();
  endtask

  task automatic test_flush();
    drive(1, 35, 0, 1, 7, 0, 1, 0, 1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_lw got %b want 0", stall); end
    tick();
    d_add(8, 7, 7);
    checks++; if (stall !== 1'b0 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      errors++; $display("FAIL flush_killed got st=%b a=%0d b=%0d want 0/0/0", stall, fwd_a, fwd_b); end
    tick();
    drain();
    d_lw(7, 1); tick();
    drive(1, 0, 32, 7, 7, 8, 1, 1, 1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_prio got %b want 0", stall); end
    tick();
    drain();
  endtask

  task automatic test_nearest_and_reset();
    d_add(9, 1, 2); tick();
    d_add(9, 3, 4); tick();
    d_add(10, 9, 9);
    checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
      errors++; $display("FAIL nearest got %0d/%0d want 1/1", fwd_a, fwd_b); end
    tick();
    drain();
    d_add(9, 1, 2); tick(); d_bub(); tick();
    d_add(10, 9, 0);
    checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL mem_fwd got %0d want 2", fwd_a); end
    tick();
    drain();
    d_add(9, 1, 2); tick(); d_bub(); tick(); d_bub(); tick();
    d_add(10, 0, 9);
    checks++; if (fwd_b !== 2'd3) begin errors++; $display("FAIL wb_fwd got %0d want 3", fwd_b); end
    tick();
    drain();
    d_add(9, 1, 2); tick();
    d_add(9, 1, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    d_add(10, 9, 9);
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall_cnt !== '0) begin
      errors++; $display("FAIL midrst got a=%0d b=%0d cnt=%0d want 0/0/0", fwd_a, fwd_b, stall_cnt); end
    tick();
    drain();
  endtask

  task automatic test_random();
    int ops[11] = '{0, 0, 0, 35, 35, 43, 8, 13, 3, 4, 2};
    int fns[6]  = '{32, 33, 42, 8, 12, 0};
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 9) != 0, ops[$urandom_range(0, 10)], fns[$urandom_range(0, 5)],
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      checks++; if (stall !== e_stall) begin
        errors++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, e_stall); end
      checks++; if (int'(fwd_a) !== e_fa || int'(fwd_b) !== e_fb) begin
        errors++; $display("FAIL rnd_fwd[%0d] got %0d/%0d want %0d/%0d", i, fwd_a, fwd_b, e_fa, e_fb); end
      checks++; if (id_wen !== e_wen || int'(id_wdst) !== e_wdst) begin
        errors++; $display("FAIL rnd_dec[%0d] got %b/%0d want %b/%0d", i, id_wen, id_wdst, e_wen, e_wdst); end
      checks++; if (int'(stall_cnt) !== m_cnt) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, stall_cnt, m_cnt); end
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CntMx + 3; i++) begin
      d_lw(5, 1); tick();
      d_add(6, 5, 0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d] got %b want 1", i, stall); end
      tick();
      d_bub(); tick();
    end
    checks++; if (int'(stall_cnt) !== CntMx) begin
      errors++; $display("FAIL sat_cnt got %0d want %0d", stall_cnt, CntMx); end
  endtask

  initial begin
    rst = 1'b1;
    d_bub();
    for (int a = 1; a <= 3; a++) begin m_v[a] = 0; m_dst[a] = 0; m_ld[a] = 0; end
    m_cnt = 0;
    test_reset();
    test_ex_forward();
    test_load_use();
    test_store();
    test_zero_and_jal();
    test_flush();
    test_nearest_and_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
